// File: rtl/neuron_param_bank.sv
// Wishbone-mapped bank of per-neuron parameter records. One record is exposed
// combinationally to the core, and an external port can write back the voltage potential.
module neuron_param_bank #(
    parameter int          NUM_NEURONS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_4000,
    parameter int          IDX_W       = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [IDX_W-1:0]        nrn_idx_i,
    input  logic                    ext_we_i,
    input  logic [IDX_W-1:0]        ext_idx_i,
    input  logic [7:0]              ext_vp_i,
    output logic signed [7:0]       vp_o,
    output logic signed [7:0]       pos_reset_o,
    output logic signed [7:0]       neg_reset_o,
    output logic signed [7:0]       w1_o,
    output logic signed [7:0]       w2_o,
    output logic signed [7:0]       w3_o,
    output logic signed [7:0]       w4_o,
    output logic signed [7:0]       leak_o,
    output logic signed [7:0]       pos_th_o,
    output logic signed [7:0]       neg_th_o,
    output logic                    weight_sel_o,
    output logic                    init_done_o
);

    typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

    localparam logic [31:0]      SPAN     = 32'(NUM_NEURONS) << 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    // Word0 = {vp, reset_val, w1, w2}; word1 = {w3, w4, leak, pos_th}
    logic [31:0] word0_mem [NUM_NEURONS];
    logic [31:0] word1_mem [NUM_NEURONS];
    logic [7:0]  nth_mem   [NUM_NEURONS];
    logic        mode_mem  [NUM_NEURONS];

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      dat_reg, dat_next;

    logic [31:0]      offset;
    logic             adr_ok;
    logic [IDX_W-1:0] rec;
    logic [1:0]       word_k;
    logic             wb_access, wb_wr, ext_active;
    logic [31:0]      cur_word, new_word, rd_word;

    assign offset     = wbs_adr_i - BASE_ADDR;
    assign adr_ok     = (offset < SPAN) && (wbs_adr_i[1:0] == 2'b00);
    assign rec        = offset[4 +: IDX_W];
    assign word_k     = offset[3:2];
    assign wb_access  = (state_reg == IDLE) && wbs_cyc_i && wbs_stb_i;
    assign wb_wr      = wb_access && wbs_we_i && adr_ok;
    assign ext_active = ext_we_i && (state_reg != INIT);

    // Current view already includes a same-cycle external vp write, so the
    // byte merge below makes a Wishbone vp byte override it naturally.
    always_comb begin
        cur_word = 32'h0;
        case (word_k)
            2'd0: begin
                cur_word = word0_mem[rec];
                if (ext_active && ext_idx_i == rec)
                    cur_word[31:24] = ext_vp_i;
            end
            2'd1:    cur_word = word1_mem[rec];
            2'd2:    cur_word = {nth_mem[rec], 7'b0, mode_mem[rec], 16'h0};
            default: cur_word = 32'h0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign new_word[gi*8 +: 8] = (wbs_we_i && wbs_sel_i[gi]) ? wbs_dat_i[gi*8 +: 8]
                                                                       : cur_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_word = 32'h0;
        case (word_k)
            2'd0, 2'd1: rd_word = new_word;
            2'd2:       rd_word = {new_word[31:24], 7'b0, new_word[16], 16'h0};
            default:    rd_word = 32'h0;
        endcase
        if (!adr_ok)
            rd_word = 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (state_reg == INIT) begin
                word0_mem[cnt_reg] <= 32'h0;
                word1_mem[cnt_reg] <= 32'h0;
                nth_mem[cnt_reg]   <= 8'h0;
                mode_mem[cnt_reg]  <= 1'b0;
            end else begin
                if (ext_active)
                    word0_mem[ext_idx_i][31:24] <= ext_vp_i;
                if (wb_wr) begin
                    case (word_k)
                        2'd0: word0_mem[rec] <= new_word;
                        2'd1: word1_mem[rec] <= new_word;
                        2'd2: begin
                            nth_mem[rec]  <= new_word[31:24];
                            mode_mem[rec] <= new_word[16];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            dat_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dat_reg   <= dat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dat_next   = dat_reg;
        case (state_reg)
            INIT: begin
                if (cnt_reg == LAST_IDX)
                    state_next = IDLE;
                else
                    cnt_next = cnt_reg + IDX_W'(1);
            end
            IDLE: begin
                if (wb_access) begin
                    state_next = ACK;
                    dat_next   = rd_word;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    assign wbs_ack_o    = (state_reg == ACK);
    assign wbs_dat_o    = dat_reg;
    assign init_done_o  = (state_reg != INIT);
    assign weight_sel_o = nrn_idx_i[0];

    assign vp_o        = word0_mem[nrn_idx_i][31:24];
    assign pos_reset_o = word0_mem[nrn_idx_i][23:16];
    assign w1_o        = word0_mem[nrn_idx_i][15:8];
    assign w2_o        = word0_mem[nrn_idx_i][7:0];
    assign w3_o        = word1_mem[nrn_idx_i][31:24];
    assign w4_o        = word1_mem[nrn_idx_i][23:16];
    assign leak_o      = word1_mem[nrn_idx_i][15:8];
    assign pos_th_o    = word1_mem[nrn_idx_i][7:0];
    assign neg_th_o    = nth_mem[nrn_idx_i];
    // Mode 0 mirrors the positive reset; two's-complement wrap keeps -(-128) = -128
    assign neg_reset_o = mode_mem[nrn_idx_i] ? nth_mem[nrn_idx_i]
                                             : 8'h00 - word0_mem[nrn_idx_i][23:16];

endmodule

// File: tb/tb_neuron_param_bank.sv
// Randomized bench for neuron_param_bank against a byte-addressed record model.
module tb_neuron_param_bank;

    localparam int          NUM  = 256;
    localparam logic [31:0] BASE = 32'h3000_4000;
    localparam int          IW   = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [IW-1:0] nrn_idx_i = '0, ext_idx_i = '0;
    logic        ext_we_i = 1'b0;
    logic [7:0]  ext_vp_i = 8'h0;
    logic signed [7:0] vp_o, pos_reset_o, neg_reset_o, w1_o, w2_o, w3_o, w4_o;
    logic signed [7:0] leak_o, pos_th_o, neg_th_o;
    logic        weight_sel_o, init_done_o;

    neuron_param_bank #(.NUM_NEURONS(NUM), .BASE_ADDR(BASE), .IDX_W(IW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .nrn_idx_i(nrn_idx_i), .ext_we_i(ext_we_i), .ext_idx_i(ext_idx_i), .ext_vp_i(ext_vp_i),
        .vp_o(vp_o), .pos_reset_o(pos_reset_o), .neg_reset_o(neg_reset_o),
        .w1_o(w1_o), .w2_o(w2_o), .w3_o(w3_o), .w4_o(w4_o),
        .leak_o(leak_o), .pos_th_o(pos_th_o), .neg_th_o(neg_th_o),
        .weight_sel_o(weight_sel_o), .init_done_o(init_done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Model: 16 bytes per record; byte (rec*16 + k*4 + lane) holds word k bits [lane*8+7:lane*8]
    logic [7:0] mdl [NUM*16];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NUM*16; i++) mdl[i] = 8'h0;
    endtask

    function automatic logic [31:0] mdl_word(input int r, input int k);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[l*8 +: 8] = mdl[r*16 + k*4 + l];
        return w;
    endfunction

    // Applies ext write then Wishbone write; returns expected read data
    task automatic mdl_access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat, input logic ew, input int eidx,
                              input logic [7:0] evp, output logic [31:0] rd);
        longint a, lo, hi;
        int r, k;
        logic [7:0] v;
        if (ew) mdl[eidx*16 + 3] = evp;
        a  = longint'(adr);
        lo = longint'(BASE);
        hi = lo + 16*NUM;
        rd = 32'h0;
        if (a >= lo && a < hi && (a % 4) == 0) begin
            r = int'((a - lo) / 16);
            k = int'(((a - lo) % 16) / 4);
            if (we) begin
                for (int l = 0; l < 4; l++) begin
                    if (sel[l] && k != 3 && !(k == 2 && l < 2)) begin
                        v = dat[l*8 +: 8];
                        if (k == 2 && l == 2) v = v & 8'h01;
                        mdl[r*16 + k*4 + l] = v;
                    end
                end
            end
            rd = mdl_word(r, k);
        end
    endtask

    task automatic chk_outs(input int idx);
        logic [7:0] rv, negr;
        logic [IW-1:0] iv;
        int b, t;
        iv = IW'(idx);
        nrn_idx_i = iv;
        #1;
        b  = idx * 16;
        rv = mdl[b+2];
        t  = (256 - int'(rv)) % 256;
        negr = mdl[b+10][0] ? mdl[b+11] : t[7:0];
        check($sformatf("outs[%0d]", idx),
              {8'h0, vp_o, pos_reset_o, neg_reset_o, w1_o, w2_o, w3_o, w4_o, leak_o, pos_th_o, neg_th_o, 7'b0, weight_sel_o},
              {8'h0, mdl[b+3], rv, negr, mdl[b+1], mdl[b+0], mdl[b+7], mdl[b+6], mdl[b+5], mdl[b+4], mdl[b+11], 7'b0, iv[0]});
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input logic ew, input int eidx, input logic [7:0] evp);
        logic [31:0] exp;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        ext_we_i = ew; ext_idx_i = IW'(eidx); ext_vp_i = evp;
        mdl_access(we, sel, adr, dat, ew, eidx, evp, exp);
        @(posedge wb_clk_i); #1;
        check("ack", {95'h0, wbs_ack_o}, 96'h1);
        check("rdata", {64'h0, wbs_dat_o}, {64'h0, exp});
        $display("wb we=%0d sel=%h adr=%h wdat=%h ext=%0d/%0d/%h rdat=%h", we, sel, adr, dat, ew, eidx, evp, wbs_dat_o);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; ext_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        check("ack_drop", {95'h0, wbs_ack_o}, 96'h0);
        check("rdata_hold", {64'h0, wbs_dat_o}, {64'h0, exp});
        @(negedge wb_clk_i);
    endtask

    task automatic ext_only(input int eidx, input logic [7:0] evp);
        logic [31:0] dummy;
        ext_we_i = 1'b1; ext_idx_i = IW'(eidx); ext_vp_i = evp;
        mdl_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, eidx, evp, dummy);
        @(posedge wb_clk_i); #1;
        ext_we_i = 1'b0;
        @(negedge wb_clk_i);
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        check({tag, "_done_low"}, {95'h0, init_done_o}, 96'h0);
        while (init_done_o !== 1'b1 && cyc < 2000) begin
            @(posedge wb_clk_i); #1;
            cyc++;
        end
        check({tag, "_cycles"}, 96'(cyc), 96'(NUM));
        mdl_clear();
        @(negedge wb_clk_i);
    endtask

    initial begin
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        we, ew;
        int          r, k, eidx, mode;

        repeat (3) @(negedge wb_clk_i);
        check("rst_ack", {95'h0, wbs_ack_o}, 96'h0);
        check("rst_dat", {64'h0, wbs_dat_o}, 96'h0);
        wb_rst_i = 1'b0;
        wait_init("init");
        for (int i = 0; i < NUM; i++) chk_outs(i);

        // Directed scenarios
        wb_xfer(1'b1, 4'hF, BASE + 32'h50, 32'h7F0A_0305, 1'b0, 0, 8'h0);
        wb_xfer(1'b0, 4'hF, BASE + 32'h50, 32'h0, 1'b0, 0, 8'h0);
        nrn_idx_i = 8'd5; #1;
        check("vp127", {88'h0, vp_o}, 96'h7F);
        check("negrst_m10", {88'h0, neg_reset_o}, 96'hF6);
        wb_xfer(1'b1, 4'b0100, BASE + 32'h54, 32'h00EE_0000, 1'b0, 0, 8'h0);
        nrn_idx_i = 8'd5; #1;
        check("w4_ee", {88'h0, w4_o}, 96'hEE);
        check("w3_kept", {88'h0, w3_o}, 96'h00);
        wb_xfer(1'b1, 4'b1000, BASE + 32'h50, 32'h2200_0000, 1'b1, 5, 8'h11);
        nrn_idx_i = 8'd5; #1;
        check("vp_wb_wins", {88'h0, vp_o}, 96'h22);
        ext_only(6, 8'h11);
        nrn_idx_i = 8'd6; #1;
        check("ext_vp6", {88'h0, vp_o}, 96'h11);
        wb_xfer(1'b0, 4'hF, BASE + 32'(16*NUM), 32'h0, 1'b0, 0, 8'h0);
        wb_xfer(1'b1, 4'hF, BASE + 32'h01, 32'hDEAD_BEEF, 1'b0, 0, 8'h0);
        wb_xfer(1'b1, 4'hF, BASE + 32'h5C, 32'hFFFF_FFFF, 1'b0, 0, 8'h0);
        chk_outs(5);
        wb_xfer(1'b1, 4'b0100, BASE + 32'h70, 32'h0080_0000, 1'b0, 0, 8'h0);
        chk_outs(7);
        nrn_idx_i = 8'd7; #1;
        check("negrst_m128", {88'h0, neg_reset_o}, 96'h80);
        wb_xfer(1'b1, 4'hF, BASE + 32'h58, 32'hFFFF_FFFF, 1'b0, 0, 8'h0);
        nrn_idx_i = 8'd5; #1;
        check("negrst_mode1", {88'h0, neg_reset_o}, 96'hFF);

        // Strobe held through ACK: no back-to-back access
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h50;
        @(posedge wb_clk_i); #1; check("hold_ack1", {95'h0, wbs_ack_o}, 96'h1);
        @(posedge wb_clk_i); #1; check("hold_gap",  {95'h0, wbs_ack_o}, 96'h0);
        @(posedge wb_clk_i); #1; check("hold_ack2", {95'h0, wbs_ack_o}, 96'h1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r    = $urandom_range(NUM-1);
            k    = $urandom_range(3);
            mode = $urandom_range(9);
            adr  = BASE + 32'(r*16 + k*4);
            if (mode == 0) adr = BASE + 32'(16*NUM) + 32'($urandom_range(255) * 4);
            if (mode == 1) adr = adr | 32'($urandom_range(1, 3));
            if (mode == 2) adr = BASE - 32'($urandom_range(1, 64) * 4);
            we   = ($urandom_range(2) != 0);
            sel  = 4'($urandom_range(15));
            dat  = $urandom;
            ew   = ($urandom_range(3) == 0);
            eidx = ($urandom_range(1) == 0) ? r : int'($urandom_range(NUM-1));
            wb_xfer(we, sel, adr, dat, ew, eidx, 8'($urandom_range(255)));
            chk_outs(r);
            chk_outs(int'($urandom_range(NUM-1)));
        end

        // Reset during ACK aborts and restarts the clear
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h54; wbs_dat_i = 32'h1234_5678;
        @(posedge wb_clk_i); #1;
        check("rst_pre_ack", {95'h0, wbs_ack_o}, 96'h1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst_ack_drop", {95'h0, wbs_ack_o}, 96'h0);
        check("rst_dat_zero", {64'h0, wbs_dat_o}, 96'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge wb_clk_i); @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wait_init("reinit");
        chk_outs(5);
        wb_xfer(1'b0, 4'hF, BASE + 32'h54, 32'h0, 1'b0, 0, 8'h0);
        wb_xfer(1'b0, 4'hF, BASE + 32'h50, 32'h0, 1'b0, 0, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/neuron_param_bank.md
NEURON_PARAM_BANK -- requirements
Module: neuron_param_bank

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 256, number of neuron parameter records (power of two, 2..256).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h30004000, byte address of record 0.
REQ-003 SHALL have parameter IDX_W, default 8, width of neuron index ports (log2 NUM_NEURONS).
REQ-004 wb_clk_i  input  1  clock; all logic on rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe, write enable.
REQ-007 wbs_sel_i  input  4  byte-lane selects; wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data.
REQ-008 wbs_ack_o  output  1  transfer acknowledge; wbs_dat_o  output  32  read data.
REQ-009 nrn_idx_i  input  IDX_W  neuron whose parameters drive the parameter outputs.
REQ-010 ext_we_i  input  1, ext_idx_i  input  IDX_W, ext_vp_i  input  8  external voltage-potential write-back.
REQ-011 vp_o, pos_reset_o, neg_reset_o, w1_o..w4_o, leak_o, pos_th_o, neg_th_o  output  8 each, signed neuron parameters.
REQ-012 weight_sel_o  output  1  = nrn_idx_i[0]; init_done_o  output  1  high once memory clear is complete.

Function
REQ-013 Record n SHALL occupy 16 bytes at BASE_ADDR + 16*n; word offset k = adr[3:2].
REQ-014 Word0 SHALL be {vp, reset_val, w1, w2}; word1 {w3, w4, leak, pos_th}; word2 {neg_th, mode, 16'h0}; word3 reserved, reads 0, writes ignored.
REQ-015 Bits [15:0] of word2 SHALL read 0 and ignore writes; only bit 0 of the mode byte is stored, other mode bits read 0.
REQ-016 FSM states INIT, IDLE, ACK; reset enters INIT with clear counter 0.
REQ-017 INIT: one record per cycle set to all-zero; after record NUM_NEURONS-1 is cleared, next state IDLE and init_done_o = 1.
REQ-018 INIT: Wishbone requests SHALL be held (no ack), ext_we_i SHALL be ignored.
REQ-019 IDLE: cyc&stb high -> perform access that cycle, ACK next; ack asserted exactly one cycle in ACK, then IDLE.
REQ-020 ACK with cyc&stb still high SHALL NOT start a new access; a new access requires one IDLE cycle.
REQ-021 Write: only bytes with wbs_sel_i set SHALL update; read data SHALL reflect post-write contents (write-through) and be registered with ack.
REQ-022 Address outside [BASE_ADDR, BASE_ADDR+16*NUM_NEURONS) or misaligned bits [1:0] != 0 SHALL be acked with wbs_dat_o = 0 and no state change.
REQ-023 ext_we_i in IDLE or ACK SHALL write ext_vp_i to vp of record ext_idx_i.
REQ-024 Same-cycle ext write and Wishbone write to byte vp of same record: Wishbone data SHALL win; other cases both take effect.
REQ-025 Parameter outputs SHALL be combinational from record nrn_idx_i; neg_reset_o = mode 0 ? -reset_val (8-bit two's complement, -(-128) = -128) : neg_th.
REQ-026 wbs_dat_o SHALL hold its last value outside ACK.

Reset
REQ-027 On wb_rst_i: wbs_ack_o = 0, wbs_dat_o = 0, init_done_o = 0, state INIT, counter 0; asserting mid-transaction aborts it without ack.
REQ-028 Memory contents SHALL be cleared only by INIT, not by the reset signal itself; parameter outputs are 0 from INIT completion.

Verification
REQ-029 Release reset -> init_done_o rises exactly NUM_NEURONS cycles later; all outputs 0 for every nrn_idx_i.
REQ-030 Write 32'h7F0A0305 sel 4'hF to BASE+0x50, read back -> ack 1 cycle after stb, data 32'h7F0A0305; nrn_idx_i=5 gives vp 127, neg_reset -10.
REQ-031 Write sel 4'b0100 data 32'h00EE0000 to BASE+0x54 -> only w4 of record 5 changes to 0xEE.
REQ-032 Same cycle ext_we_i idx 5 vp 0x11 and Wishbone write vp byte 0x22 -> vp 0x22; ext write to idx 6 alone -> record 6 vp 0x11.
REQ-033 Read BASE+16*NUM_NEURONS and BASE+0x01 -> ack with data 0, no memory change.
REQ-034 Assert wb_rst_i during ACK -> ack drops immediately, INIT restarts, record 5 reads 0 after completion.
